// File: rtl/wb_stream_master.sv
// Wishbone classic single-transfer initiator driven by a val/rdy command stream.
// Optional bus timeout is enabled by defining WB_TIMEOUT_EN.
module wb_stream_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_recv_we,
   input  logic [31:0] cmd_recv_addr,
   input  logic [31:0] cmd_recv_data,
   input  logic [3:0]  cmd_recv_sel,
   input  logic        cmd_recv_val,
   output logic        cmd_recv_rdy,
   output logic [31:0] resp_send_msg,
   output logic        resp_send_err,
   output logic        resp_send_val,
   input  logic        resp_send_rdy,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_stream_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] msg_q, msg_d;
   logic        val_q, val_d;
   logic        err_q, err_d;
   logic        timeout;

`ifdef WB_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;

   // Held at zero outside BUS, so every BUS entry starts counting from 0.
   assign cnt_d   = (state_q == StBus) ? cnt_q + 16'd1 : 16'd0;
   assign timeout = (state_q == StBus) && (cnt_q == TimeoutLast) && !wbm_ack_i;

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 16'd0;
      else       cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      msg_d   = msg_q;
      val_d   = val_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_recv_val) begin
               we_d    = cmd_recv_we;
               sel_d   = cmd_recv_sel;
               adr_d   = cmd_recv_addr;
               dat_d   = cmd_recv_data;
               cyc_d   = 1'b1;
               state_d = StBus;
            end
         end
         StBus: begin
            // Ack takes priority over a timeout landing on the same cycle.
            if (wbm_ack_i) begin
               cyc_d   = 1'b0;
               msg_d   = we_q ? 32'd0 : wbm_dat_i;
               err_d   = 1'b0;
               val_d   = 1'b1;
               state_d = StResp;
            end else if (timeout) begin
               cyc_d   = 1'b0;
               msg_d   = 32'd0;
               err_d   = 1'b1;
               val_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (resp_send_rdy) begin
               val_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         msg_q   <= 32'd0;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         msg_q   <= msg_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   assign cmd_recv_rdy  = (state_q == StIdle);
   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_we_o      = we_q;
   assign wbm_sel_o     = sel_q;
   assign wbm_adr_o     = adr_q;
   assign wbm_dat_o     = dat_q;
   assign resp_send_msg = msg_q;
   assign resp_send_val = val_q;
   assign resp_send_err = err_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Self-checking bench for wb_stream_master; scoreboard of expected responses.
module tb_wb_stream_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_recv_we;
   logic [31:0] cmd_recv_addr;
   logic [31:0] cmd_recv_data;
   logic [3:0]  cmd_recv_sel;
   logic        cmd_recv_val;
   logic        cmd_recv_rdy;
   logic [31:0] resp_send_msg;
   logic        resp_send_err;
   logic        resp_send_val;
   logic        resp_send_rdy;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   typedef struct packed {
      logic [31:0] msg;
      logic        err;
   } resp_t;

   resp_t       exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_msg = 32'd0;

   wb_stream_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_recv_we   (cmd_recv_we),
      .cmd_recv_addr (cmd_recv_addr),
      .cmd_recv_data (cmd_recv_data),
      .cmd_recv_sel  (cmd_recv_sel),
      .cmd_recv_val  (cmd_recv_val),
      .cmd_recv_rdy  (cmd_recv_rdy),
      .resp_send_msg (resp_send_msg),
      .resp_send_err (resp_send_err),
      .resp_send_val (resp_send_val),
      .resp_send_rdy (resp_send_rdy),
      .wbm_cyc_o     (wbm_cyc_o),
      .wbm_stb_o     (wbm_stb_o),
      .wbm_we_o      (wbm_we_o),
      .wbm_sel_o     (wbm_sel_o),
      .wbm_adr_o     (wbm_adr_o),
      .wbm_dat_o     (wbm_dat_o),
      .wbm_dat_i     (wbm_dat_i),
      .wbm_ack_i     (wbm_ack_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Present a command and hold it until accepted; returns in the first BUS cycle.
   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n = 0;
      cmd_recv_we   = we;
      cmd_recv_addr = a;
      cmd_recv_data = d;
      cmd_recv_sel  = s;
      cmd_recv_val  = 1'b1;
      while (!cmd_recv_rdy && n < 20) begin
         step();
         n++;
      end
      if (!cmd_recv_rdy) begin
         checks++;
         errors++;
         $display("FAIL issue_accept: rdy=%b required 1", cmd_recv_rdy);
      end
      step();
      cmd_recv_val = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'd0) begin
         errors++;
         $display("FAIL reset_wbm: got %h required 0",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
      end
      checks++;
      if ({resp_send_val, resp_send_err, resp_send_msg} !== 34'd0) begin
         errors++;
         $display("FAIL reset_resp: got %h required 0",
                  {resp_send_val, resp_send_err, resp_send_msg});
      end
      checks++;
      if (cmd_recv_rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdy: got %b required 1", cmd_recv_rdy);
      end
   endtask

   task automatic test_write();
      resp_t e;
      exp_q.push_back('{msg: 32'd0, err: 1'b0});
      issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
          {3'b111, 4'hF, 32'h3000_0004, 32'hA5A5_1234}) begin
         errors++;
         $display("FAIL write_bus: got %h required %h",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
                  {3'b111, 4'hF, 32'h3000_0004, 32'hA5A5_1234});
      end
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
      checks++;
      if ({resp_send_val, wbm_stb_o, cmd_recv_rdy} !== 3'b100) begin
         errors++;
         $display("FAIL write_resp_state: val/stb/rdy got %b required 100",
                  {resp_send_val, wbm_stb_o, cmd_recv_rdy});
      end
      e = exp_q.pop_front();
      last_msg = e.msg;
      checks++;
      if ({resp_send_msg, resp_send_err} !== e) begin
         errors++;
         $display("FAIL write_resp: got %h required %h", {resp_send_msg, resp_send_err}, e);
      end
      step();
      checks++;
      if ({cmd_recv_rdy, resp_send_val} !== 2'b10) begin
         errors++;
         $display("FAIL write_turnaround: rdy/val got %b required 10",
                  {cmd_recv_rdy, resp_send_val});
      end
   endtask

   task automatic test_read_wait();
      resp_t e;
      int    n = 0;
      int    stb_cycles = 0;
      logic  stable = 1'b1;
      exp_q.push_back('{msg: 32'hDEAD_BEEF, err: 1'b0});
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      wbm_dat_i = 32'hDEAD_BEEF;
      while (!resp_send_val && n < 30) begin
         if (wbm_stb_o) begin
            stb_cycles++;
            if ({wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o} !== {2'b10, 4'hF, 32'h3000_0010})
               stable = 1'b0;
         end
         wbm_ack_i = (stb_cycles == 5);
         step();
         n++;
      end
      wbm_ack_i = 1'b0;
      checks++;
      if (stb_cycles != 5 || wbm_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL read_stb_cycles: got %0d (stb now %b) required 5", stb_cycles, wbm_stb_o);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL read_bus_stable: got unstable required stable");
      end
      if (exp_q.size() == 0 || !resp_send_val) begin
         checks++;
         errors++;
         $display("FAIL read_resp_missing: val=%b required 1", resp_send_val);
      end else begin
         e = exp_q.pop_front();
         last_msg = e.msg;
         checks++;
         if ({resp_send_msg, resp_send_err} !== e) begin
            errors++;
            $display("FAIL read_resp: got %h required %h", {resp_send_msg, resp_send_err}, e);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      resp_t e;
      logic  held = 1'b1;
      exp_q.push_back('{msg: 32'h1234_5678, err: 1'b0});
      resp_send_rdy = 1'b0;
      issue(1'b0, 32'h3000_0020, 32'h0, 4'h3);
      wbm_dat_i = 32'h1234_5678;
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if ({resp_send_val, cmd_recv_rdy, resp_send_msg} !== {2'b10, 32'h1234_5678})
            held = 1'b0;
         if (i == 2) cmd_recv_val = 1'b1;
         step();
      end
      checks++;
      if (!held || wbm_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold: val/rdy/msg got %b%b/%h required 10/12345678 cyc=%b",
                  resp_send_val, cmd_recv_rdy, resp_send_msg, wbm_cyc_o);
      end
      cmd_recv_val = 1'b0;
      e = exp_q.pop_front();
      last_msg = e.msg;
      checks++;
      if ({resp_send_val, resp_send_msg, resp_send_err} !== {1'b1, e}) begin
         errors++;
         $display("FAIL bp_resp: got %h required %h",
                  {resp_send_val, resp_send_msg, resp_send_err}, {1'b1, e});
      end
      resp_send_rdy = 1'b1;
      step();
      exp_q.push_back('{msg: 32'd0, err: 1'b0});
      issue(1'b1, 32'h3000_0024, 32'h0000_00AA, 4'h1);
      checks++;
      if ({wbm_stb_o, wbm_adr_o} !== {1'b1, 32'h3000_0024}) begin
         errors++;
         $display("FAIL bp_next_cmd: got %h required %h", {wbm_stb_o, wbm_adr_o},
                  {1'b1, 32'h3000_0024});
      end
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
      e = exp_q.pop_front();
      last_msg = e.msg;
      checks++;
      if ({resp_send_val, resp_send_msg, resp_send_err} !== {1'b1, e}) begin
         errors++;
         $display("FAIL bp_next_resp: got %h required %h",
                  {resp_send_val, resp_send_msg, resp_send_err}, {1'b1, e});
      end
      step();
   endtask

   task automatic test_spurious_ack();
      resp_t e;
      wbm_dat_i = 32'hFFFF_FFFF;
      wbm_ack_i = 1'b1;
      repeat (2) step();
      wbm_ack_i = 1'b0;
      checks++;
      if ({cmd_recv_rdy, resp_send_val, wbm_cyc_o, resp_send_msg} !== {3'b100, last_msg}) begin
         errors++;
         $display("FAIL spurious_idle: got %h required %h",
                  {cmd_recv_rdy, resp_send_val, wbm_cyc_o, resp_send_msg}, {3'b100, last_msg});
      end
      exp_q.push_back('{msg: 32'h0BAD_F00D, err: 1'b0});
      resp_send_rdy = 1'b0;
      issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
      wbm_dat_i = 32'h0BAD_F00D;
      wbm_ack_i = 1'b1;
      step();
      wbm_dat_i = 32'hFFFF_FFFF;
      repeat (2) step();
      wbm_ack_i = 1'b0;
      e = exp_q.pop_front();
      last_msg = e.msg;
      checks++;
      if ({resp_send_val, cmd_recv_rdy, wbm_cyc_o, resp_send_msg, resp_send_err} !==
          {3'b100, e}) begin
         errors++;
         $display("FAIL spurious_resp: got %h required %h",
                  {resp_send_val, cmd_recv_rdy, wbm_cyc_o, resp_send_msg, resp_send_err},
                  {3'b100, e});
      end
      resp_send_rdy = 1'b1;
      step();
      wbm_dat_i = 32'h0;
   endtask

   task automatic test_reset_mid_bus();
      logic seen = 1'b0;
      issue(1'b1, 32'h3000_0040, 32'h5555_AAAA, 4'hC);
      checks++;
      if (wbm_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_bus_pre: stb got %b required 1", wbm_stb_o);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           resp_send_val, resp_send_msg, cmd_recv_rdy} !== {104'd0, 1'b1}) begin
         errors++;
         $display("FAIL rst_bus_outputs: cyc/stb/val/rdy got %b%b%b%b adr %h required 0001 0",
                  wbm_cyc_o, wbm_stb_o, resp_send_val, cmd_recv_rdy, wbm_adr_o);
      end
      last_msg = 32'd0;
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
      repeat (3) begin
         if (resp_send_val) seen = 1'b1;
         step();
      end
      checks++;
      if (seen || cmd_recv_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_bus_no_resp: resp seen %b rdy %b required 0 1", seen, cmd_recv_rdy);
      end
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout(input int ack_at, input logic [31:0] rdata);
      resp_t e;
      int    n = 0;
      int    stb_cycles = 0;
      if (ack_at == 0) exp_q.push_back('{msg: 32'd0, err: 1'b1});
      else             exp_q.push_back('{msg: rdata, err: 1'b0});
      issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
      wbm_dat_i = rdata;
      while (!resp_send_val && n < 30) begin
         if (wbm_stb_o) stb_cycles++;
         wbm_ack_i = (ack_at != 0) && (stb_cycles == ack_at);
         step();
         n++;
      end
      wbm_ack_i = 1'b0;
      checks++;
      if (stb_cycles != 8 || wbm_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_stb_cycles: got %0d required 8", stb_cycles);
      end
      if (exp_q.size() == 0 || !resp_send_val) begin
         checks++;
         errors++;
         $display("FAIL timeout_resp_missing: val=%b required 1", resp_send_val);
      end else begin
         e = exp_q.pop_front();
         last_msg = e.msg;
         checks++;
         if ({resp_send_msg, resp_send_err} !== e) begin
            errors++;
            $display("FAIL timeout_resp: got %h required %h", {resp_send_msg, resp_send_err}, e);
         end
      end
      step();
      wbm_dat_i = 32'h0;
   endtask
`endif

   initial begin
      reset         = 1'b1;
      cmd_recv_we   = 1'b0;
      cmd_recv_addr = 32'd0;
      cmd_recv_data = 32'd0;
      cmd_recv_sel  = 4'd0;
      cmd_recv_val  = 1'b0;
      resp_send_rdy = 1'b1;
      wbm_dat_i     = 32'd0;
      wbm_ack_i     = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_backpressure();
      test_spurious_ack();
      test_reset_mid_bus();
`ifdef WB_TIMEOUT_EN
      test_timeout(0, 32'h0);
      test_timeout(8, 32'hCAFE_0008);
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stream_master.md
Name: wb_stream_master

Overview:
- Wishbone classic single-transfer initiator for the host side of the coprocessor Wishbone slave port.
- Converts a val/rdy command stream (read or write, address, data, byte select) into one Wishbone bus cycle per command.
- Returns exactly one response per command on a val/rdy response stream.
- Serves as the bench/host driver pushing instructions and load data into the vector coprocessor and reading back store data.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles waited for wbm_ack_i before abort (used only with WB_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  input  1  single clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- cmd_recv_we  input  1  1 = write, 0 = read
- cmd_recv_addr  input  32  byte address
- cmd_recv_data  input  32  write data (ignored for reads)
- cmd_recv_sel  input  4  byte lane select
- cmd_recv_val  input  1  command valid
- cmd_recv_rdy  output  1  command accepted when val & rdy
- resp_send_msg  output  32  read data (0 for writes)
- resp_send_err  output  1  1 = transfer aborted by timeout
- resp_send_val  output  1  response valid
- resp_send_rdy  input  1  response consumer ready
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte select
- wbm_adr_o  output  32  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_dat_i  input  32  Wishbone read data
- wbm_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Reset values (all outputs registered or state-decoded):
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0; wbm_sel_o = 0; wbm_adr_o = wbm_dat_o = 0.
  - resp_send_val = 0, resp_send_msg = 0, resp_send_err = 0.
  - State = IDLE, so cmd_recv_rdy = 1 in the first cycle after reset.
- State machine IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - cmd_recv_rdy = 1.
  - On cmd_recv_val & cmd_recv_rdy: latch we/addr/data/sel into the wbm_* registers, set cyc = stb = 1, go to BUS.
  - cmd_recv_rdy is 0 in every other state.
- BUS:
  - cyc, stb, we, sel, adr and dat_o are held stable until ack.
  - On wbm_ack_i = 1: clear cyc/stb on the same edge; capture resp_send_msg = wbm_dat_i for reads or 0 for writes; set err = 0 and resp_send_val = 1; go to RESP.
- RESP:
  - resp_send_val, msg and err are held until resp_send_rdy = 1.
  - On that edge, clear resp_send_val and return to IDLE.
  - A new command is accepted no earlier than the following cycle.
- Latency and throughput:
  - Command accept to cyc/stb high: 1 cycle.
  - ack to resp_send_val high: 1 cycle.
  - Minimum 3 cycles per transaction with zero-wait ack and resp_send_rdy = 1.
- wbm_ack_i in IDLE or RESP is ignored: no state change, no data capture.
- Only one outstanding transfer; response order equals command order.
- Reset mid-operation (any state): all outputs return to reset values on that edge; the in-flight command and pending response are discarded.
- wbm_sel_o is passed through unmodified; no address alignment checking.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUS and increments every cycle in BUS without ack.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack: clear cyc/stb, set resp_send_msg = 0 and resp_send_err = 1, assert resp_send_val, go to RESP.
  - If ack arrives in the same cycle as the timeout, ack wins (err = 0, data captured).
- Not defined:
  - BUS waits for ack indefinitely.
  - No counter is instantiated.
  - resp_send_err is tied to 0.

Test Plan:
- Write: cmd we=1, addr 0x3000_0004, data 0xA5A5_1234, sel 0xF; slave acks in the cycle after stb.
  -> wbm_adr_o/dat_o/sel_o/we_o match and are stable while stb = 1; one response with msg 0, err 0; 3-cycle turnaround.
- Read with 4 wait states: cmd we=0, addr 0x3000_0010; slave returns 0xDEAD_BEEF with ack on the 5th BUS cycle.
  -> stb high for exactly 5 cycles; resp_send_msg = 0xDEAD_BEEF one cycle after ack.
- Response backpressure: resp_send_rdy = 0 for 6 cycles after a read completes.
  -> resp_send_val and msg held stable; cmd_recv_rdy = 0 throughout; next command accepted only after the response handshake.
- Spurious ack in IDLE and RESP.
  -> no state change; resp_send_msg unchanged.
- Reset mid-BUS: assert reset for 1 cycle while stb = 1.
  -> cyc/stb = 0 on the next edge; no response produced; cmd_recv_rdy = 1 the next cycle.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and no ack.
  -> stb drops after 8 BUS cycles; response err = 1, msg 0.
  -> Repeat with ack arriving on cycle 8: err = 0 and data captured.
